// File: rtl/math_multiplier_addback.sv
// Sequential shift-and-add multiply-add: x = q*y + r, one multiplier bit per clock.
// Optional remainder-range flag is built when MATH_MULTIPLIER_REMCHECK_EN is defined.
module math_multiplier_addback #(
    parameter int xWIDTH = 8,
    parameter int yWIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [xWIDTH-1:0]         q,
    input  logic [yWIDTH-1:0]         y,
    input  logic [yWIDTH-1:0]         r,
    output logic                      busy,
    output logic                      done,
    output logic [xWIDTH+yWIDTH-1:0]  x,
    output logic                      err
);
    localparam int W  = xWIDTH + yWIDTH;
    localparam int CW = $clog2(yWIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(yWIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q;
    logic [W-1:0]      mcand_q;
    logic [W-1:0]      acc_q;
    logic [W-1:0]      acc_d;
    logic [yWIDTH-1:0] mplier_q;
    logic [CW-1:0]     cnt_q;
    logic [W-1:0]      x_q;
    logic              busy_q;
    logic              done_q;
    logic              accept;
    logic              finish;

    // The addend seeds the accumulator, so the final sum needs no extra add cycle.
    always_comb begin
        acc_d  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        accept = start && (state_q != RUN);
        finish = (state_q == RUN) && (cnt_q == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            x_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        mcand_q  <= W'(q);
                        mplier_q <= y;
                        acc_q    <= W'(r);
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (finish) begin
                        x_q     <= acc_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign x    = x_q;

`ifdef MATH_MULTIPLIER_REMCHECK_EN
    logic err_pend_q;
    logic err_q;

    // r >= y also flags y == 0, since any r is out of range for a zero divisor.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pend_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (accept) err_pend_q <= (r >= y);
            if (finish) err_q      <= err_pend_q;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_math_multiplier_addback.sv
// Directed self-checking bench for math_multiplier_addback (8x4 default widths).
module tb_math_multiplier_addback;
    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  q;
    logic [3:0]  y;
    logic [3:0]  r;
    logic        busy;
    logic        done;
    logic [11:0] x;
    logic        err;

    int total = 0;
    int bad   = 0;

`ifdef MATH_MULTIPLIER_REMCHECK_EN
    localparam bit REMCHK = 1'b1;
`else
    localparam bit REMCHK = 1'b0;
`endif

    math_multiplier_addback #(.xWIDTH(8), .yWIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .q     (q),
        .y     (y),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .x     (x),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one accept edge, then wait (bounded) for done.
    task automatic do_op(input logic [7:0] qi, input logic [3:0] yi, input logic [3:0] ri,
                         output int lat);
        q = qi; y = yi; r = ri; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        int lat;
        rst = 1'b1; start = 1'b0; q = '0; y = '0; r = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (x !== 12'd0) begin bad++; $display("FAIL reset_x got=%0d exp=0", x); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        rst = 1'b0;
        q = 8'd200; y = 4'd13; r = 4'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL first_busy got=%b exp=1", busy); end
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("op q=200 y=13 r=7 x=%0d lat=%0d err=%b", x, lat, err);
        total++; if (lat !== 4) begin bad++; $display("FAIL first_latency got=%0d exp=4", lat); end
        total++; if (x !== 12'd2607) begin bad++; $display("FAIL first_x got=%0d exp=2607", x); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL first_busy_done got=%b exp=0", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL first_err got=%b exp=0", err); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_pulse got=%b exp=0", done); end
        total++; if (x !== 12'd2607) begin bad++; $display("FAIL x_hold got=%0d exp=2607", x); end
    endtask

    task automatic test_roundtrip();
        int lat;
        for (int d = 0; d < 256; d++) begin
            for (int yy = 1; yy < 16; yy++) begin
                do_op(8'(d / yy), 4'(yy), 4'(d % yy), lat);
                $display("rt d=%0d y=%0d x=%0d lat=%0d err=%b", d, yy, x, lat, err);
                total++; if (lat !== 4) begin bad++; $display("FAIL rt_latency d=%0d y=%0d got=%0d exp=4", d, yy, lat); end
                total++; if (x !== 12'(d)) begin bad++; $display("FAIL rt_x d=%0d y=%0d got=%0d exp=%0d", d, yy, x, d); end
                total++; if (err !== 1'b0) begin bad++; $display("FAIL rt_err d=%0d y=%0d got=%b exp=0", d, yy, err); end
            end
        end
        @(posedge clk); #1;
        $display("EOT");
    endtask

    task automatic test_extremes();
        int lat;
        do_op(8'd255, 4'd15, 4'd15, lat);
        $display("op q=255 y=15 r=15 x=%0d err=%b", x, err);
        total++; if (x !== 12'd3840) begin bad++; $display("FAIL max_x got=%0d exp=3840", x); end
        total++; if (err !== REMCHK) begin bad++; $display("FAIL max_err got=%b exp=%b", err, REMCHK); end
        do_op(8'd0, 4'd0, 4'd9, lat);
        $display("op q=0 y=0 r=9 x=%0d err=%b", x, err);
        total++; if (lat !== 4) begin bad++; $display("FAIL y0_latency got=%0d exp=4", lat); end
        total++; if (x !== 12'd9) begin bad++; $display("FAIL y0_x got=%0d exp=9", x); end
        total++; if (err !== REMCHK) begin bad++; $display("FAIL y0_err got=%b exp=%b", err, REMCHK); end
        do_op(8'd37, 4'd0, 4'd2, lat);
        $display("op q=37 y=0 r=2 x=%0d err=%b", x, err);
        total++; if (x !== 12'd2) begin bad++; $display("FAIL y0b_x got=%0d exp=2", x); end
        @(posedge clk); #1;
    endtask

    // start held high, operands changing every cycle; accepts land on cycles 0,5,10,15.
    task automatic test_back_to_back();
        logic [7:0] qv [0:19];
        logic [3:0] yv [0:19];
        logic [3:0] rv [0:19];
        int a;
        logic [11:0] exp_x;
        logic exp_err;
        for (int c = 0; c < 20; c++) begin
            qv[c] = 8'((c * 37 + 11) & 255);
            yv[c] = 4'((c * 5 + 3) & 15);
            rv[c] = 4'((c * 7 + 1) & 15);
        end
        start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            q = qv[c]; y = yv[c]; r = rv[c];
            @(posedge clk); #1;
            if ((c % 5) == 4) begin
                a = c - 4;
                exp_x = 12'(qv[a]) * 12'(yv[a]) + 12'(rv[a]);
                exp_err = REMCHK && (rv[a] >= yv[a]);
                $display("b2b cyc=%0d q=%0d y=%0d r=%0d x=%0d err=%b", c, qv[a], yv[a], rv[a], x, err);
                total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done cyc=%0d got=%b exp=1", c, done); end
                total++; if (x !== exp_x) begin bad++; $display("FAIL b2b_x cyc=%0d got=%0d exp=%0d", c, x, exp_x); end
                total++; if (err !== exp_err) begin bad++; $display("FAIL b2b_err cyc=%0d got=%b exp=%b", c, err, exp_err); end
            end else begin
                total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_nodone cyc=%0d got=%b exp=0", c, done); end
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy cyc=%0d got=%b exp=1", c, busy); end
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        q = 8'd100; y = 4'd7; r = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("midrst busy=%b done=%b x=%0d", busy, done, x);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", done); end
        total++; if (x !== 12'd0) begin bad++; $display("FAIL midrst_x got=%0d exp=0", x); end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midrst_stray_done got=%0d exp=0", seen); end
        do_op(8'd100, 4'd7, 4'd3, lat);
        $display("op q=100 y=7 r=3 x=%0d lat=%0d", x, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL fresh_latency got=%0d exp=4", lat); end
        total++; if (x !== 12'd703) begin bad++; $display("FAIL fresh_x got=%0d exp=703", x); end
    endtask

    initial begin
        test_reset();
        test_roundtrip();
        test_extremes();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
